// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light display path: segment codes,
// digit indices and the per-slot scan state.
package traffic_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIG_A1 = 2'd0;
    localparam digit_idx_t DIG_A0 = 2'd1;
    localparam digit_idx_t DIG_B1 = 2'd2;
    localparam digit_idx_t DIG_B0 = 2'd3;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_t;

    // Active-low enable pattern with only the selected digit pulled low.
    function automatic logic [3:0] digit_enable(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic is_tens_digit(input digit_idx_t idx);
        return (idx == DIG_A1) || (idx == DIG_B1);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Segment-code bundle between the counter logic and the multiplexed display
// driver; the master supplies codes, the slave drives the display pins.
interface seg_scan_driver_if;

    logic [6:0] segA1;
    logic [6:0] segA0;
    logic [6:0] segB1;
    logic [6:0] segB0;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic       frame_tick;

    modport master (
        output segA1, segA0, segB1, segB0,
        input  seg_out, an, frame_tick
    );

    modport slave (
        input  segA1, segA0, segB1, segB0,
        output seg_out, an, frame_tick
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot timing for the display scan: cycle counter within a digit slot,
// current digit index, and the BLANK/DRIVE phase of the slot.
module seg_scan_timer
    import traffic_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    output digit_idx_t idx,
    output logic       frame_start,
    output logic       in_blank
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    slot_state_t      state_q, state_d;
    logic             slot_wrap;

    assign slot_wrap = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Phase is switched one cycle early so state_q always matches cnt_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_q == BLANK_END) state_d = DRIVE;
            DRIVE:   if (slot_wrap)          state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= DIG_A1;
            state_q <= BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign idx         = idx_q;
    assign in_blank    = (state_q == BLANK);
    assign frame_start = (cnt_q == '0) && (idx_q == DIG_A1);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with inter-digit blanking and
// per-frame shadow latching. Define SEG_SCAN_LZ_BLANK_EN to blank zero tens digits.
module seg_scan_driver
    import traffic_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_driver_if.slave   bus
);

    digit_idx_t idx;
    logic       frame_start;
    logic       in_blank;

    logic [6:0] shadow_q [4];
    logic [6:0] shadow_d [4];
    logic [6:0] seg_out_q, seg_out_d;
    logic [3:0] an_q, an_d;
    logic       frame_tick_q, frame_tick_d;

    seg_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .idx         (idx),
        .frame_start (frame_start),
        .in_blank    (in_blank)
    );

    // Shadow load always lands in a blank phase, so the driven code is never half-updated.
    always_comb begin
        shadow_d     = shadow_q;
        frame_tick_d = 1'b0;
        an_d         = 4'b1111;
        seg_out_d    = SEG_BLANK;

        if (frame_start) begin
            shadow_d[DIG_A1] = bus.segA1;
            shadow_d[DIG_A0] = bus.segA0;
            shadow_d[DIG_B1] = bus.segB1;
            shadow_d[DIG_B0] = bus.segB0;
            frame_tick_d     = 1'b1;
        end

        if (!in_blank) begin
            an_d      = digit_enable(idx);
            seg_out_d = shadow_q[idx];
`ifdef SEG_SCAN_LZ_BLANK_EN
            if (is_tens_digit(idx) && (shadow_q[idx] == SEG_ZERO)) begin
                seg_out_d = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q     <= '{default: SEG_BLANK};
            seg_out_q    <= SEG_BLANK;
            an_q         <= 4'b1111;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            seg_out_q    <= seg_out_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.seg_out    = seg_out_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a frame-position
// reference model (DIGIT_CYCLES=8, BLANK_CYCLES=2).
module tb_seg_scan_driver;

    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * DC;

    logic clk;
    logic reset;

    seg_scan_driver_if bus();

    seg_scan_driver #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int         pos;
    logic [6:0] model_shadow [4];
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_tick;
    logic [3:0] last_an;
    logic       seen_digit;
    int         blank_run;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a1, input logic [6:0] a0,
                                 input logic [6:0] b1, input logic [6:0] b0);
        bus.segA1 = a1;
        bus.segA0 = a0;
        bus.segB1 = b1;
        bus.segB0 = b0;
    endtask

    function automatic logic [6:0] randCode(input logic allow_zero);
        logic [6:0] c;
        c = 7'($urandom_range(0, 127));
        if (allow_zero && ($urandom_range(0, 1) == 1)) c = 7'b0000001;
        return c;
    endfunction

    task automatic modelReset();
        pos = 0;
        for (int i = 0; i < 4; i++) model_shadow[i] = 7'b1111111;
    endtask

    // One clock: predict the output registered at this edge, then compare at the falling edge.
    task automatic stepClock();
        int         slot;
        int         off;
        logic [3:0] one;
        @(posedge clk);
        one = 4'b0001;
        if (!reset) begin
            exp_an   = 4'b1111;
            exp_seg  = 7'b1111111;
            exp_tick = 1'b0;
            modelReset();
        end else begin
            slot     = pos / DC;
            off      = pos % DC;
            exp_tick = (pos == 0);
            if (off >= BC) begin
                exp_an  = ~(one << slot);
                exp_seg = model_shadow[slot];
`ifdef SEG_SCAN_LZ_BLANK_EN
                if ((slot == 0 || slot == 2) && model_shadow[slot] == 7'b0000001)
                    exp_seg = 7'b1111111;
`endif
            end else begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end
            if (pos == 0) begin
                model_shadow[0] = bus.segA1;
                model_shadow[1] = bus.segA0;
                model_shadow[2] = bus.segB1;
                model_shadow[3] = bus.segB0;
            end
            pos = (pos + 1) % FRAME;
        end
        @(negedge clk);
        checkOutput("an", 32'(bus.an), 32'(exp_an));
        checkOutput("seg_out", 32'(bus.seg_out), 32'(exp_seg));
        checkOutput("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
        checkOutput("one_hot_an", 32'($countones(~bus.an) <= 1), 32'd1);
        if (bus.an != 4'b1111) begin
            if (seen_digit && bus.an != last_an)
                checkOutput("blank_gap", 32'(blank_run >= BC), 32'd1);
            last_an    = bus.an;
            seen_digit = 1'b1;
            blank_run  = 0;
        end else begin
            blank_run++;
        end
    endtask

    initial begin
        seen_digit = 1'b0;
        blank_run  = 0;
        last_an    = 4'b1111;
        modelReset();
        reset = 1'b0;
        applyStimulus(randCode(0), randCode(0), randCode(0), randCode(0));

        // Reset held with arbitrary inputs.
        for (int i = 0; i < 5; i++) begin
            stepClock();
            applyStimulus(randCode(0), randCode(0), randCode(0), randCode(0));
        end

        // Directed digits 1,2,3,4; segB0 changes mid-frame during the second frame.
        applyStimulus(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);
        reset = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            stepClock();
            if (i == FRAME + DC + 3) bus.segB0 = 7'b0100100;
        end

        // Tens digits showing zero.
        applyStimulus(7'b0000001, 7'b0010010, 7'b0000001, 7'b1001100);
        for (int i = 0; i < 2 * FRAME; i++) stepClock();

        // Random inputs changing at random points in the frame.
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 7) == 0)
                applyStimulus(randCode(1), randCode(0), randCode(1), randCode(0));
            stepClock();
        end

        // Reset pulled during the drive phase of digit B1.
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (pos == 2 * DC + BC + 3) break;
            stepClock();
        end
        checkOutput("pre_reset_an", 32'(bus.an), 32'(4'b1011));
        reset = 1'b0;
        #1;
        checkOutput("async_an", 32'(bus.an), 32'(4'b1111));
        checkOutput("async_seg", 32'(bus.seg_out), 32'(7'b1111111));
        checkOutput("async_tick", 32'(bus.frame_tick), 32'd0);
        modelReset();
        applyStimulus(7'b0110000, 7'b0000001, 7'b1111001, 7'b0001111);
        for (int i = 0; i < 3; i++) stepClock();
        reset = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) stepClock();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage of the traffic-light controller. Consumes the four active-low 7-segment codes (lane A tens/units, lane B tens/units) and time-multiplexes them onto one shared segment bus with four active-low digit enables.
- Inserts a blanking gap between digits to suppress ghosting. Latches all four codes once per frame so a frame never mixes old and new counter values.

Parameters:
- DIGIT_CYCLES, 50000, clk cycles per digit slot (blank + drive); must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 500, cycles at start of each slot with all digits off; must be ≥ 1.
- CNT_W, 16, slot counter width; must satisfy 2^CNT_W ≥ DIGIT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- segA1  in  7  lane A tens code, active-low, bit6=a … bit0=g
- segA0  in  7  lane A units code
- segB1  in  7  lane B tens code
- segB0  in  7  lane B units code
- seg_out  out  7  shared segment bus, active-low
- an  out  4  digit enables, active-low; an[0]=A1, an[1]=A0, an[2]=B1, an[3]=B0
- frame_tick  out  1  one-cycle pulse when the shadow registers load

Behaviour:
- Reset (reset=0, asynchronous): cnt=0, idx=0, state=BLANK, an=4'b1111, seg_out=7'b1111111, frame_tick=0, all four shadow regs=7'b1111111.
- Slot counter: cnt increments every clk. At cnt==DIGIT_CYCLES-1: cnt→0 and idx→idx+1 (3 wraps to 0).
- Per-slot FSM:
  - BLANK while cnt<BLANK_CYCLES.
  - DRIVE while BLANK_CYCLES ≤ cnt ≤ DIGIT_CYCLES-1.
  - BLANK→DRIVE at cnt==BLANK_CYCLES.
  - DRIVE→BLANK at slot wrap.
- Shadow load:
  - On the edge where cnt==0 and idx==0, shadow[0..3] ← {segA1, segA0, segB1, segB0}. frame_tick=1 for exactly that following cycle.
  - Also applies to the first edge after reset release.
- Outputs are registered from the current cnt/idx, so they lag cnt by one cycle:
  - BLANK: an=4'b1111, seg_out=7'b1111111.
  - DRIVE: an=~(4'b0001<<idx), seg_out=shadow[idx].
- The shadow load edge always falls in BLANK (BLANK_CYCLES ≥ 1), so stale shadow data is never driven.
- Inputs changing mid-frame have no visible effect until the next frame boundary.
- Never more than one an bit low at any time; no cycle with two digits enabled across a slot boundary.
- Reset asserted mid-slot: outputs blank immediately (asynchronous). Scanning restarts at idx=0 with a fresh shadow load.
- Frame period = 4·DIGIT_CYCLES cycles.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression. When a tens code (shadow[0] or shadow[2]) equals the digit-0 code 7'b0000001, that digit's DRIVE slot outputs seg_out=7'b1111111 with its an bit still low. Slot timing is unchanged.
- Undefined: tens digits are always displayed as latched.

Decomposition:
- Shared package traffic_pkg holds:
  - SEG_BLANK=7'b1111111 and SEG_ZERO=7'b0000001.
  - Digit index typedef (2-bit) with constants DIG_A1=0, DIG_A0=1, DIG_B1=2, DIG_B0=3.
  - Slot state enum {BLANK, DRIVE}.
- One natural sub-module: seg_scan_timer. It holds cnt and idx and produces slot_wrap, frame_start and in_blank strobes. Shadow registers and output muxing stay in the top.

Test Plan (DIGIT_CYCLES=8, BLANK_CYCLES=2):
- Reset held low, inputs arbitrary → an=4'b1111, seg_out=7'b1111111, frame_tick=0 throughout.
- Release reset with segA1=7'b1001111, segA0=7'b0010010, segB1=7'b0000110, segB0=7'b1001100 → frame_tick high cycle 1. Per 8-cycle slot: 2 blank cycles, then 6 cycles an=1110/1101/1011/0111 with seg_out=1,2,3,4 codes respectively. Frame repeats every 32 cycles.
- Change segB0 to 7'b0100100 during the idx=1 slot → remaining frame still shows 7'b1001100 on an=0111. The next frame shows 7'b0100100.
- Every cycle over 4 frames → popcount(~an) ≤ 1. At least 2 all-high an cycles between each pair of enabled digits.
- Pull reset low mid-DRIVE of idx=2 → next sample an=4'b1111. After release, scanning restarts at an=4'b1110 with frame_tick at cycle 1.
- With SEG_SCAN_LZ_BLANK_EN and segA1=7'b0000001 → idx=0 slot drives an=4'b1110, seg_out=7'b1111111. Without the macro, seg_out=7'b0000001.
